mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Moore-style main controller for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back over several clocks, and shares one unified memory port between instructions and data.
- It decodes the opcode and funct fields and drives every datapath select and enable.
- It stretches memory states until the memory handshakes, and counts retired instructions.
- It sits beside the datapath, replacing the single-cycle combinational control.

Parameters:
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- Control_CLK  input  1  system clock, rising edge.
- Control_RST  input  1  reset, asynchronous, active-low.
- Opcode  input  6  Instr[31:26] from the instruction register.
- Funct  input  6  Instr[5:0] from the instruction register.
- Zero_flag  input  1  ALU zero flag.
- Mem_Ready  input  1  memory completes the current access this cycle.
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- IRWrite  output  1  load the instruction register.
- MemWrite  output  1  memory write strobe.
- PCEn  output  1  load the PC; equals PCWrite | (Branch & Zero_flag).
- PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- RegDst  output  1  0 = rt, 1 = rd.
- MemtoReg  output  1  0 = ALUOut, 1 = data register.
- RegWrite  output  1  register-file write enable.
- Illegal_Instr  output  1  sticky unsupported-opcode/funct flag.
- Instr_Count  output  CNT_WIDTH  retired instructions.

Behaviour:
- Reset:
  - State = IDLE; Illegal_Instr = 0; Instr_Count = 0.
  - In IDLE all outputs are 0 and ALUControl = 010.
  - IDLE -> FETCH on the first clock after reset release.
  - Reset asserted in any state aborts immediately; no write strobe may remain high.
- States and outputs (signals not listed are 0; ALUControl = 010 unless stated):
  - FETCH: IorD = 0, ALUSrcA = 0, ALUSrcB = 01, PCSrc = 00. IRWrite = Mem_Ready and PCWrite = Mem_Ready. Stays in FETCH while Mem_Ready = 0; advances to DECODE when Mem_Ready = 1.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11 (branch target into ALUOut). Next state by opcode:
    - 100011 / 101011 -> MEMADR
    - 000000 with legal funct -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEXEC
    - 000010 -> JUMP
    - anything else -> FETCH, with Illegal_Instr set.
  - Legal funct values are 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct on an R-type is treated as illegal the same way.
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10. Next state is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: IorD = 1. Holds until Mem_Ready, then -> MEMWB.
  - MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1. -> FETCH.
  - MEMWRITE: IorD = 1, MemWrite = 1. Holds, with MemWrite high, until Mem_Ready = 1, then -> FETCH.
  - EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALUControl decoded from Funct. -> ALUWB.
  - ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1. -> FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 110, Branch = 1, PCSrc = 01. -> FETCH.
  - ADDIEXEC: ALUSrcA = 1, ALUSrcB = 10. -> ADDIWB.
  - ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1. -> FETCH.
  - JUMP: PCSrc = 10, PCWrite = 1. -> FETCH.
- Output timing:
  - All outputs are combinational from the state register plus Funct, Zero_flag and Mem_Ready only.
  - No output depends on Opcode outside DECODE.
- Retirement:
  - Instr_Count increments by 1 on exit from MEMWB, MEMWRITE (with Mem_Ready), ALUWB, BRANCH, ADDIWB and JUMP.
  - Illegal instructions are not counted.
  - The counter wraps from all-ones to 0.
- Latency in clocks, with Mem_Ready tied to 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Stall rule:
  - While stalled, no architectural write (PCEn, IRWrite, RegWrite) is asserted.
  - Only MemWrite is held, and only in MEMWRITE.
- Illegal_Instr: sticky; cleared only by reset.

Decomposition:
- Shared package holds:
  - state encoding (4-bit localparams);
  - opcode and funct constants;
  - ALUControl codes;
  - ALUSrcB and PCSrc encodings.
- One sub-module, mips_alu_decoder: combinational Funct -> ALUControl, plus a funct_legal output.

Test Plan:
- Reset mid-MEMWRITE: assert Control_RST low while MemWrite = 1 -> MemWrite falls immediately, state is IDLE, Instr_Count = 0.
- lw (Opcode 100011), Mem_Ready = 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite = 1 only in cycle 5 with MemtoReg = 1. Instr_Count 0 -> 1.
- sw with Mem_Ready low for 3 cycles in MEMWRITE -> MemWrite high for 4 cycles. PCEn/IRWrite/RegWrite stay 0 throughout. Count increments once.
- R-type sub (Funct 100010) -> ALUControl = 110 in EXECUTE. RegDst = 1 and RegWrite = 1 in ALUWB.
- beq in BRANCH: Zero_flag = 1 -> PCEn = 1, PCSrc = 01; Zero_flag = 0 -> PCEn = 0. Count increments in both cases.
- Opcode 111111, then R-type Funct 000000 -> each returns to FETCH after DECODE. Illegal_Instr = 1 and stays 1. Count unchanged.

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// state codes, opcode/funct constants, ALU and mux select codes.
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// mux selects, write enables, sticky error flag and retire count out.
interface mips_multicycle_control_if #(
    parameter int CNT_WIDTH = 16
);
    logic [5:0]           Opcode;
    logic [5:0]           Funct;
    logic                 Zero_flag;
    logic                 Mem_Ready;
    logic                 IorD;
    logic                 IRWrite;
    logic                 MemWrite;
    logic                 PCEn;
    logic [1:0]           PCSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ALUControl;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 RegWrite;
    logic                 Illegal_Instr;
    logic [CNT_WIDTH-1:0] Instr_Count;

    modport slave (
        input  Opcode, Funct, Zero_flag, Mem_Ready,
        output IorD, IRWrite, MemWrite, PCEn, PCSrc,
        output ALUSrcA, ALUSrcB, ALUControl,
        output RegDst, MemtoReg, RegWrite,
        output Illegal_Instr, Instr_Count
    );

    modport master (
        output Opcode, Funct, Zero_flag, Mem_Ready,
        input  IorD, IRWrite, MemWrite, PCEn, PCSrc,
        input  ALUSrcA, ALUSrcB, ALUControl,
        input  RegDst, MemtoReg, RegWrite,
        input  Illegal_Instr, Instr_Count
    );
endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// R-type funct decoder: funct -> ALU operation, plus legality flag.
// Ports: funct in; alu_control, funct_legal out.
module mips_alu_decoder
    import mips_multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_legal
);

    always_comb begin
        alu_control = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore main controller for the multicycle MIPS datapath.
// Ports: Control_CLK, Control_RST (async, active-low), ctrl bundle.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                      Control_CLK,
    input  logic                      Control_RST,
    mips_multicycle_control_if.slave  ctrl
);

    state_t               state;
    state_t               next_state;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] count;

    logic [2:0] funct_alu;
    logic       funct_legal;

    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu_control;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       retire;
    logic       set_illegal;

    mips_alu_decoder u_alu_decoder (
        .funct       (ctrl.Funct),
        .alu_control (funct_alu),
        .funct_legal (funct_legal)
    );

    always_ff @(posedge Control_CLK or negedge Control_RST) begin
        if (!Control_RST) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
            count   <= '0;
        end else begin
            state <= next_state;
            if (set_illegal)
                illegal <= 1'b1;
            if (retire)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        iord        = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        pc_src      = PCSRC_ALU;
        src_a       = 1'b0;
        src_b       = SRCB_REG;
        alu_control = ALU_ADD;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        unique case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                src_b    = SRCB_FOUR;
                ir_write = ctrl.Mem_Ready;
                pc_write = ctrl.Mem_Ready;
                if (ctrl.Mem_Ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                src_b = SRCB_IMM_SH;
                case (ctrl.Opcode)
                    OP_LW,
                    OP_SW:   next_state = S_MEMADR;
                    OP_BEQ:  next_state = S_BRANCH;
                    OP_ADDI: next_state = S_ADDIEXEC;
                    OP_J:    next_state = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_legal) begin
                            next_state = S_EXECUTE;
                        end else begin
                            next_state  = S_FETCH;
                            set_illegal = 1'b1;
                        end
                    end
                    default: begin
                        next_state  = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a = 1'b1;
                src_b = SRCB_IMM;
                // Only lw/sw reach here, so the opcode reduces to one bit.
                next_state = (ctrl.Opcode == OP_LW) ? S_MEMREAD
                                                    : S_MEMWRITE;
            end
            S_MEMREAD: begin
                iord = 1'b1;
                if (ctrl.Mem_Ready)
                    next_state = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (ctrl.Mem_Ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXECUTE: begin
                src_a       = 1'b1;
                alu_control = funct_alu;
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                src_a       = 1'b1;
                alu_control = ALU_SUB;
                branch      = 1'b1;
                pc_src      = PCSRC_ALUOUT;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_ADDIEXEC: begin
                src_a      = 1'b1;
                src_b      = SRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign ctrl.IorD          = iord;
    assign ctrl.IRWrite       = ir_write;
    assign ctrl.MemWrite      = mem_write;
    assign ctrl.PCEn          = pc_write | (branch & ctrl.Zero_flag);
    assign ctrl.PCSrc         = pc_src;
    assign ctrl.ALUSrcA       = src_a;
    assign ctrl.ALUSrcB       = src_b;
    assign ctrl.ALUControl    = alu_control;
    assign ctrl.RegDst        = reg_dst;
    assign ctrl.MemtoReg      = mem_to_reg;
    assign ctrl.RegWrite      = reg_write;
    assign ctrl.Illegal_Instr = illegal;
    assign ctrl.Instr_Count   = count;

endmodule
